id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  RV32I decode/operand-fetch stage between fetch and execute. Decodes the instruction
//  and drives the register-file read addresses. Latches operands, immediate and control
//  fields into the ID/EX pipeline register, with valid/ready handshakes on both sides.
//  Adds write-back bypass: the RF reads combinationally and writes on the clock edge, so a
//  same-cycle write would otherwise be missed. Detects load-use hazards and inserts bubbles.
// PARAMETERS
//  XLEN       32  datapath width (operands, pc, immediate)
//  RA_W       5   register address width
//  BYPASS_EN  1   1: WB->ID bypass active; 0: operands taken from RF only
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous reset, active-high
//  flush        in   1     kill the ID/EX contents and the in-flight input (branch/jump redirect)
//  in_valid     in   1     fetch presents in_instr/in_pc
//  in_ready     out  1     stage accepts input this cycle
//  in_instr     in   32    instruction word
//  in_pc        in   XLEN  instruction address
//  rf_rs1       out  RA_W  RF read address 1 = in_instr[19:15]
//  rf_rs2       out  RA_W  RF read address 2 = in_instr[24:20]
//  rf_d1        in   XLEN  RF read data 1
//  rf_d2        in   XLEN  RF read data 2
//  wb_we        in   1     write-back enable (same signal as the RF write enable)
//  wb_rd        in   RA_W  write-back destination
//  wb_data      in   XLEN  write-back data
//  ex_valid     out  1     ID/EX register holds a valid instruction
//  ex_ready     in   1     execute consumes ID/EX this cycle
//  ex_pc        out  XLEN  captured pc
//  ex_op1       out  XLEN  rs1 value (bypassed)
//  ex_op2       out  XLEN  rs2 value (bypassed)
//  ex_imm       out  XLEN  sign-extended immediate (I/S/B/U/J per opcode; 0 for R-type)
//  ex_rd        out  RA_W  destination register
//  ex_rd_we     out  1     destination written (R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR, rd!=0)
//  ex_opcode    out  7     instr[6:0]
//  ex_funct3    out  3     instr[14:12]
//  ex_f7b5      out  1     instr[30]
//  ex_is_load   out  1     opcode 0000011
//  ex_illegal   out  1     opcode outside RV32I base set
// BEHAVIOUR
//  Reset: ex_valid=0 and every ex_* output=0. in_ready follows its equation (is 1 once ex_valid=0).
//  Operand select: x0 reads 0. Else if BYPASS_EN and wb_we and wb_rd==rsN, use wb_data;
//    else use rf_dN. The bypass is combinational, so the captured value has 0 extra latency.
//  Register use: rs1 is used by R, I-ALU, LOAD, STORE, BRANCH, JALR; rs2 by R, STORE, BRANCH.
//  hazard = ex_valid & ex_is_load & ex_rd!=0 & (ex_rd matches a *used* rs1/rs2 of in_instr).
//  adv = !ex_valid | ex_ready;  in_ready = flush | (adv & !hazard).
//  Edge priority: rst > flush > adv. flush: ex_valid<=0 and the input is dropped (handshake
//    completes). adv & in_valid & !hazard: capture input, ex_valid<=1. adv & (hazard |
//    !in_valid): ex_valid<=0 (bubble). !adv: all ex_* hold (stable while ex_valid & !ex_ready).
//  Hazard stall: one bubble per hazard. Once the load leaves ID/EX the instruction is accepted.
//  Illegal opcode: the instruction is still captured with ex_illegal=1 and ex_rd_we=0.
//  S/B-type: ex_rd_we=0, and ex_rd carries instr[11:7] unchanged.
// TESTING
//  T1 reset: rst high 2 cycles -> ex_valid=0, all ex_*=0; first cycle after rst low, in_ready=1.
//  T2 decode: ADDI x5,x4,-3 with rf_d1=42 -> next edge ex_op1=42, ex_imm=32'hFFFFFFFD,
//     ex_rd=5, ex_rd_we=1.
//  T3 bypass: ADD x3,x2,x4 while wb_we=1, wb_rd=2, wb_data=99, rf_d1=0 -> ex_op1=99.
//     Repeat with BYPASS_EN=0 -> ex_op1=0. rs=x0 with wb_rd=0, wb_data=7 -> ex_op1=0.
//  T4 load-use: LW x6 in ID/EX, then ADD x7,x6,x1 offered -> in_ready=0 for 1 cycle, one
//     bubble (ex_valid=0), then ADD captured. LUI x6 after LW x6 -> no stall.
//  T5 backpressure: ex_ready=0 for 3 cycles with a valid entry -> ex_* stable, in_ready=0.
//     Release -> the next instruction is captured on the same edge.
//  T6 flush: flush=1 with ex_valid=1 and in_valid=1 -> in_ready=1, next edge ex_valid=0,
//     and the dropped instruction never appears on ex_*.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: RV32I decode / operand-fetch stage feeding the ID/EX pipeline register.
// Combines register-file reads with a write-back bypass and stalls one cycle on load-use.
module id_stage #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,

  output logic [RA_W-1:0] rf_rs1,
  output logic [RA_W-1:0] rf_rs2,
  input  logic [XLEN-1:0] rf_d1,
  input  logic [XLEN-1:0] rf_d2,

  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,

  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_rd_we,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_f7b5,
  output logic            ex_is_load,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RA_W-1:0] rs1;
  logic [RA_W-1:0] rs2;
  logic [RA_W-1:0] rd;

  imm_fmt_e        imm_fmt;
  logic            writes_rd;
  logic            use_rs1;
  logic            use_rs2;
  logic            illegal;
  logic            is_load;
  logic            rd_we;

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  logic            load_pending;
  logic            hazard;
  logic            adv;
  logic            take;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[15 +: RA_W];
  assign rs2    = in_instr[20 +: RA_W];
  assign rd     = in_instr[7 +: RA_W];

  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  // FENCE and SYSTEM are legal base-ISA opcodes but write no register here.
  always_comb begin
    imm_fmt   = IMM_NONE;
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm_fmt   = IMM_U;
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm_fmt   = IMM_J;
        writes_rd = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        imm_fmt   = IMM_I;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
      end
      OP_BRANCH: begin
        imm_fmt = IMM_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_STORE: begin
        imm_fmt = IMM_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_REG: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        imm_fmt = IMM_I;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign is_load = (opcode == OP_LOAD);
  assign rd_we   = writes_rd & (rd != '0);

  always_comb begin
    imm = '0;
    case (imm_fmt)
      IMM_I: imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      IMM_S: imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B: imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'h000};
      IMM_J: imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // The RF writes on the edge we capture on, so a same-cycle WB must be forwarded.
  always_comb begin
    op1 = rf_d1;
    if (rs1 == '0) begin
      op1 = '0;
    end else if (BYPASS_EN && wb_we && (wb_rd == rs1)) begin
      op1 = wb_data;
    end
  end

  always_comb begin
    op2 = rf_d2;
    if (rs2 == '0) begin
      op2 = '0;
    end else if (BYPASS_EN && wb_we && (wb_rd == rs2)) begin
      op2 = wb_data;
    end
  end

  assign load_pending = ex_valid & ex_is_load & (ex_rd != '0);
  assign hazard       = load_pending &
                        ((use_rs1 & (ex_rd == rs1)) | (use_rs2 & (ex_rd == rs2)));
  assign adv          = ~ex_valid | ex_ready;
  assign in_ready     = flush | (adv & ~hazard);
  assign take         = adv & in_valid & ~hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      ex_valid <= take;
    end
  end

  // Payload only moves on a real capture; bubbles and flushes leave it parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_rd_we   <= 1'b0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_f7b5    <= 1'b0;
      ex_is_load <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!flush && take) begin
      ex_pc      <= in_pc;
      ex_op1     <= op1;
      ex_op2     <= op2;
      ex_imm     <= imm;
      ex_rd      <= rd;
      ex_rd_we   <= rd_we & ~illegal;
      ex_opcode  <= opcode;
      ex_funct3  <= funct3;
      ex_f7b5    <= in_instr[30];
      ex_is_load <= is_load;
      ex_illegal <= illegal;
    end
  end

endmodule
